// File: rtl/hd_pkg.sv
// hd_pkg: shared types and sizes for the Hamming(7,4) pair deserialiser
package hd_pkg;
   localparam int CW_W      = 7;
   localparam int PAIR_BITS = 2 * CW_W;
   localparam int IDX_W     = $clog2(PAIR_BITS);
   typedef enum logic {HUNT, COLLECT} state_t;
endpackage

// File: rtl/hd_pair_deser.sv
// hd_pair_deser: collects a serial bit stream into 7-bit code word pairs behind valid/ready
module hd_pair_deser #(
   parameter int CW_W  = 7,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             in_start,
   input  logic             in_bit,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CW_W-1:0]  code_word1,
   output logic [CW_W-1:0]  code_word2,
   output logic [CNT_W-1:0] drop_cnt
);
   import hd_pkg::*;
   localparam int PW = 2 * CW_W;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(PW - 1);
   state_t           state_q, state_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic [PW-1:0]    sr_q, sr_d, sr_sh;
   logic             out_valid_q, out_valid_d;
   logic [CW_W-1:0]  cw1_q, cw1_d, cw2_q, cw2_d;
   logic [CNT_W-1:0] drop_q, drop_d;
   logic             accept;
   assign in_ready   = !(state_q == COLLECT && cnt_q == LAST && out_valid_q && !out_ready);
   assign accept     = in_valid && in_ready;
   assign sr_sh      = {sr_q[PW-2:0], in_bit};
   assign out_valid  = out_valid_q;
   assign code_word1 = cw1_q;
   assign code_word2 = cw2_q;
   assign drop_cnt   = drop_q;
   // next state: start bits (re)open a pair, the last bit publishes it, consumption frees the output
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sr_d        = sr_q;
      cw1_d       = cw1_q;
      cw2_d       = cw2_q;
      drop_d      = drop_q;
      out_valid_d = out_valid_q && !out_ready;
      if (accept && in_start) begin
         drop_d  = (state_q == COLLECT && !(&drop_q)) ? drop_q + CNT_W'(1) : drop_q;
         state_d = COLLECT;
         cnt_d   = IDX_W'(1);
         sr_d    = {{(PW-1){1'b0}}, in_bit};
      end else if (accept && state_q == COLLECT) begin
         sr_d  = sr_sh;
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + IDX_W'(1);
         if (cnt_q == LAST) begin
            state_d     = HUNT;
            cw1_d       = sr_sh[PW-1:CW_W];
            cw2_d       = sr_sh[CW_W-1:0];
            out_valid_d = 1'b1;
         end
      end
   end
   // state, shift register, output pair and drop counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= HUNT;
         cnt_q       <= '0;
         sr_q        <= '0;
         cw1_q       <= '0;
         cw2_q       <= '0;
         drop_q      <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sr_q        <= sr_d;
         cw1_q       <= cw1_d;
         cw2_q       <= cw2_d;
         drop_q      <= drop_d;
         out_valid_q <= out_valid_d;
      end
   end
endmodule

// File: tb/tb_hd_pair_deser.sv
// tb_hd_pair_deser: scoreboard bench for the serial-to-pair deserialiser
module tb_hd_pair_deser;
   logic       clk = 1'b0, rst = 1'b1;
   logic       in_valid = 1'b0, in_start = 1'b0, in_bit = 1'b0, out_ready = 1'b1;
   logic       in_ready, out_valid;
   logic [6:0] code_word1, code_word2;
   logic [7:0] drop_cnt;
   logic [13:0] sb[$];
   int n_cmp = 0, n_bad = 0;

   hd_pair_deser #(.CW_W(7), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_start(in_start), .in_bit(in_bit),
      .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
      .code_word1(code_word1), .code_word2(code_word2), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // inputs change on negedge; 2 time units later they are what the next posedge will see
   always begin
      @(negedge clk);
      #2;
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) chk("spurious_pair", {18'b0, code_word1, code_word2}, 32'hdead);
         else begin
            logic [13:0] e;
            e = sb.pop_front();
            chk("cw1", {25'b0, code_word1}, {25'b0, e[13:7]});
            chk("cw2", {25'b0, code_word2}, {25'b0, e[6:0]});
         end
      end
   end

   task automatic send_bit(input logic b, input logic s, input int gap, output logic first);
      logic acc;
      acc   = 1'b0;
      first = 1'b0;
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      in_valid = 1'b1;
      in_bit   = b;
      in_start = s;
      for (int n = 0; n < 50 && !acc; n++) begin
         #1;
         acc = in_ready;
         if (n == 0) first = acc;
         @(negedge clk);
      end
      if (!acc) chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      in_start = 1'b0;
   endtask

   task automatic send_pair(input logic [6:0] a, input logic [6:0] b, input int nbits,
                            input logic push, input int maxgap);
      logic [13:0] p;
      logic f;
      p = {a, b};
      for (int i = 0; i < nbits; i++) begin
         if (push && i == 13) sb.push_back(p);
         send_bit(p[13-i], i == 0, maxgap == 0 ? 0 : int'($urandom_range(0, maxgap)), f);
      end
   endtask

   initial begin
      logic f, all_f;
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic f, all_f;
      logic [13:0] pb;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", {31'b0, out_valid}, 0);
      chk("rst_cw1", {25'b0, code_word1}, 0);
      chk("rst_cw2", {25'b0, code_word2}, 0);
      chk("rst_drop", {24'b0, drop_cnt}, 0);
      chk("rst_in_ready", {31'b0, in_ready}, 1);
      // basic pair with latency check
      send_pair(7'b1011010, 7'b0110011, 13, 1'b0, 0);
      chk("pre_valid", {31'b0, out_valid}, 0);
      sb.push_back({7'b1011010, 7'b0110011});
      send_bit(1'b1, 1'b0, 0, f);
      chk("lat_valid", {31'b0, out_valid}, 1);
      chk("lat_cw1", {25'b0, code_word1}, 32'h5a);
      chk("basic_drop", {24'b0, drop_cnt}, 0);
      @(negedge clk);
      // hunting: unframed bits are ignored
      for (int i = 0; i < 5; i++) send_bit(i[0], 1'b0, 0, f);
      chk("hunt_valid", {31'b0, out_valid}, 0);
      send_pair(7'h7f, 7'h00, 14, 1'b1, 0);
      chk("hunt_drop", {24'b0, drop_cnt}, 0);
      // resync after 9 bits
      send_pair(7'h55, 7'h2a, 9, 1'b0, 0);
      send_pair(7'h01, 7'h40, 14, 1'b1, 0);
      chk("resync_drop", {24'b0, drop_cnt}, 1);
      @(negedge clk);
      // back-pressure: A held, B stalls only on its last bit
      out_ready = 1'b0;
      send_pair(7'h33, 7'h4c, 14, 1'b1, 0);
      chk("bp_a_valid", {31'b0, out_valid}, 1);
      pb = {7'h6e, 7'h11};
      all_f = 1'b1;
      for (int i = 0; i < 13; i++) begin
         send_bit(pb[13-i], i == 0, 0, f);
         all_f &= f;
      end
      chk("bp_b_accepted", {31'b0, all_f}, 1);
      in_valid = 1'b1;
      in_bit   = pb[0];
      #1;
      chk("bp_stall", {31'b0, in_ready}, 0);
      repeat (3) @(negedge clk);
      chk("bp_hold_cw1", {25'b0, code_word1}, 32'h33);
      chk("bp_hold_cw2", {25'b0, code_word2}, 32'h4c);
      sb.push_back(pb);
      out_ready = 1'b1;
      #1;
      chk("bp_release", {31'b0, in_ready}, 1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp_no_bubble", {31'b0, out_valid}, 1);
      chk("bp_b_cw1", {25'b0, code_word1}, 32'h6e);
      @(negedge clk);
      // random gaps
      for (int k = 0; k < 4; k++)
         send_pair(7'($urandom), 7'($urandom), 14, 1'b1, 3);
      repeat (3) @(negedge clk);
      // reset mid-pair at bit 10
      send_pair(7'h12, 7'h34, 10, 1'b0, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_valid", {31'b0, out_valid}, 0);
      chk("mid_rst_cw1", {25'b0, code_word1}, 0);
      chk("mid_rst_cw2", {25'b0, code_word2}, 0);
      chk("mid_rst_drop", {24'b0, drop_cnt}, 0);
      chk("mid_rst_ready", {31'b0, in_ready}, 1);
      send_pair(7'h2b, 7'h5d, 14, 1'b1, 0);
      @(negedge clk);
      // saturation: each start bit inside a pair is a drop
      send_bit(1'b0, 1'b1, 0, f);
      for (int i = 0; i < 255; i++) send_bit(1'b1, 1'b1, 0, f);
      chk("sat_255", {24'b0, drop_cnt}, 255);
      for (int i = 0; i < 45; i++) send_bit(1'b0, 1'b1, 0, f);
      chk("sat_hold", {24'b0, drop_cnt}, 255);
      send_pair(7'h0f, 7'h70, 14, 1'b1, 0);
      chk("sat_after_pair", {24'b0, drop_cnt}, 255);
      repeat (3) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/hd_pair_deser.md
Name: hd_pair_deser

Overview:
- Upstream feeder for the Hamming(7,4) pair decoder.
- Collects a bit-serial stream into pairs of 7-bit code words and presents each pair in parallel on code_word1/code_word2 behind a valid/ready handshake.
- Provides frame resynchronisation (in_start), back-pressure (in_ready) and a saturating counter of discarded partial pairs.

Parameters:
- CW_W, 7, code word width in bits.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  single clock, all logic rising-edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  serial bit valid.
- in_start  input  1  marks the first bit of a pair; sampled only when a bit is accepted.
- in_bit  input  1  serial data bit.
- in_ready  output  1  block can accept a bit this cycle.
- out_valid  output  1  code_word1/code_word2 hold a complete pair.
- out_ready  input  1  downstream consumes the pair.
- code_word1  output  CW_W  first code word of the pair.
- code_word2  output  CW_W  second code word of the pair.
- drop_cnt  output  CNT_W  count of partial pairs discarded, saturating.

Behaviour:
- Accept rule: a bit is accepted when in_valid && in_ready.
- Bit order:
  - Bits 0..6 of a pair fill code_word1[6] down to code_word1[0], MSB first.
  - Bits 7..13 fill code_word2[6] down to code_word2[0].
- States: HUNT (no pair in progress) and COLLECT (bit index cnt 1..13 pending).
- HUNT:
  - An accepted bit with in_start=1 is stored as bit 0; go to COLLECT with cnt=1.
  - An accepted bit with in_start=0 is discarded silently; drop_cnt is unchanged.
- COLLECT:
  - An accepted bit with in_start=0 is stored at index cnt; cnt increments.
  - On acceptance of bit 13:
    - the 14-bit shift register loads the output registers;
    - out_valid=1 from the next cycle;
    - state returns to HUNT.
  - An accepted bit with in_start=1 discards the partial pair, increments drop_cnt, and becomes bit 0 of a new pair (cnt=1, stay in COLLECT).
- Gaps: in_valid low pauses collection indefinitely. There is no timeout.
- Latency: out_valid rises exactly one cycle after the acceptance of bit 13.
- Output holding:
  - code_word1/code_word2 stay stable while out_valid=1 and out_ready=0.
  - out_valid clears the cycle after out_valid && out_ready, unless a new pair completes in that same cycle.
- Back-pressure:
  - in_ready = !(state==COLLECT && cnt==13 && out_valid && !out_ready).
  - The block stalls only on the completing bit. All other bits are accepted while the output is occupied.
- Simultaneous completion and consume: if bit 13 is accepted in the same cycle as out_valid && out_ready, the new pair loads and out_valid stays 1 with no bubble.
- drop_cnt saturates at 2^CNT_W-1 and never wraps.
- Reset: rst=1 at a clock edge forces all of the following, regardless of state:
  - state=HUNT, cnt=0;
  - out_valid=0, code_word1=0, code_word2=0;
  - drop_cnt=0, shift register=0.
  - in_ready=1 from the first cycle after reset.
  - Any partial pair or pending output is lost and is not counted.

Decomposition:
- Shared package hd_pkg holds:
  - CW_W, and PAIR_BITS=2*CW_W;
  - the state enum {HUNT, COLLECT};
  - the cnt width $clog2(PAIR_BITS).
- No sub-module. A single module holds the FSM, shift register, output register and counter.

Test Plan:
- Basic pair: with out_ready=1, in_start on the first bit, stream 1011010 then 0110011 -> one cycle after bit 13, out_valid=1, code_word1=7'b1011010, code_word2=7'b0110011, drop_cnt=0.
- Hunting: send 5 bits with in_start=0 from reset, then a proper pair 1111111/0000000 -> only one out_valid pulse with 7'h7F/7'h00, drop_cnt=0.
- Resync: send 9 bits of a pair, then in_start=1 with a full pair 0000001/1000000 -> drop_cnt=1, output 7'h01/7'h40.
- Back-pressure: out_ready=0, complete pair A, then stream pair B -> in_ready=0 only on B's bit 13. Pair A remains stable on the outputs. Raise out_ready -> B loads the next cycle and out_valid stays 1.
- Gaps and reset: insert random in_valid=0 gaps, output must match the gap-free result. Assert rst at bit 10 -> all outputs 0 and the next clean pair decodes correctly.
- Saturation: force 300 resync drops with CNT_W=8 -> drop_cnt=255 and stays there.
